// File: rtl/bcd_serial_subtractor.sv
// rtl/bcd_serial_subtractor.sv - digit-serial packed-BCD subtractor, A - B as magnitude plus sign
//
// Processes one decimal digit per clock, least significant digit first.
// ADD pass: A plus the nines complement of B, which yields an end-around carry (eac).
// FIX pass: eac=1 adds the end-around carry; eac=0 takes the nines complement.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  operation request, sampled only while idle
//   a, b   packed-BCD minuend / subtrahend, digit 0 in bits [3:0]
//   busy   operation in progress
//   done   one-cycle completion pulse
//   diff   BCD magnitude |A - B|
//   neg    A < B (never set for a zero result)
//   err    a digit greater than 9 was seen in a or b at capture
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                neg,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]  a_q, b_q, s_q, diff_q;
  logic [IW-1:0] idx_q;
  logic          c_q, eac_q, done_q, neg_q, err_q;

  logic          operand_bad;
  logic          last_digit;
  logic [4:0]    add_sum, add_adj, fix_sum, fix_adj;
  logic [3:0]    add_digit, fix_digit;
  logic          add_carry, fix_carry;

  // Any non-decimal digit in either operand aborts the operation.
  always_comb begin
    operand_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
        operand_bad = 1'b1;
      end
    end
  end

  assign last_digit = (idx_q == IW'(DIGITS - 1));

  // Operands and the partial result move through shift registers, so the
  // active digit is always in bits [3:0].
  always_comb begin
    add_sum   = {1'b0, a_q[3:0]} + {1'b0, 4'd9 - b_q[3:0]} + {4'd0, c_q};
    add_adj   = add_sum - 5'd10;
    add_carry = (add_sum > 5'd9);
    add_digit = add_carry ? add_adj[3:0] : add_sum[3:0];

    fix_sum   = {1'b0, s_q[3:0]} + {4'd0, c_q};
    fix_adj   = fix_sum - 5'd10;
    if (eac_q) begin
      fix_carry = (fix_sum > 5'd9);
      fix_digit = fix_carry ? fix_adj[3:0] : fix_sum[3:0];
    end else begin
      fix_carry = 1'b0;
      fix_digit = 4'd9 - s_q[3:0];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = operand_bad ? S_DONE : S_ADD;
        end
      end
      S_ADD:   if (last_digit) state_d = S_FIX;
      S_FIX:   if (last_digit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  assign done = done_q;
  assign diff = diff_q;
  assign neg  = neg_q;
  assign err  = err_q;

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      idx_q  <= '0;
      c_q    <= 1'b0;
      eac_q  <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
      neg_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            s_q   <= '0;
            idx_q <= '0;
            c_q   <= 1'b0;
            eac_q <= 1'b0;
            err_q <= operand_bad;
            if (operand_bad) begin
              diff_q <= '0;
              neg_q  <= 1'b0;
            end
          end
        end
        S_ADD: begin
          a_q <= a_q >> 4;
          b_q <= b_q >> 4;
          s_q <= (s_q >> 4) | (W'(add_digit) << (W - 4));
          if (last_digit) begin
            eac_q <= add_carry;
            c_q   <= 1'b1;  // seed for the end-around carry pass
            idx_q <= '0;
          end else begin
            c_q   <= add_carry;
            idx_q <= idx_q + IW'(1);
          end
        end
        S_FIX: begin
          s_q <= (s_q >> 4) | (W'(fix_digit) << (W - 4));
          c_q <= fix_carry;
          if (last_digit) begin
            idx_q <= '0;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        S_DONE: begin
          done_q <= 1'b1;
          if (!err_q) begin
            diff_q <= s_q;
            // A zero result is always reported as positive.
            neg_q  <= ~eac_q & (s_q != '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// tb/tb_bcd_serial_subtractor.sv - self-checking bench for bcd_serial_subtractor
module tb_bcd_serial_subtractor;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, neg, err;
  logic [W-1:0] diff;

  int checks = 0;
  int errors = 0;

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .neg   (neg),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [W-1:0] exp_diff;
    logic         exp_neg;
    logic         exp_err;
    int           exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference: plain integer subtraction of the decoded operands.
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [W-1:0] d, output logic n, output logic e, output int lat);
    int r;
    e = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) e = 1'b1;
    end
    if (e) begin
      d = '0; n = 1'b0; lat = 1;
    end else begin
      r = bcd2int(av) - bcd2int(bv);
      n = (r < 0);
      if (r < 0) r = -r;
      d = int2bcd(r);
      lat = 2 * DIGITS + 1;
    end
  endtask

  // Issue one start, scramble operands after capture, wait for done.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        output logic [W-1:0] d, output logic n, output logic e,
                        output int lat, output int busy_cnt,
                        output logic busy_at_done, output logic done_drop);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    lat = 0; busy_cnt = 0;
    if (busy) busy_cnt++;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) break;
      if (busy) busy_cnt++;
    end
    d = diff; n = neg; e = err; busy_at_done = busy;
    @(negedge clk);
    done_drop = ~done;
  endtask

  task automatic check_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ed, input logic en, input logic ee, input int el);
    logic [W-1:0] d;
    logic n, e, bad, drop;
    int lat, bc;
    run_op(av, bv, d, n, e, lat, bc, bad, drop);
    check({name, " diff"}, 32'(d), 32'(ed));
    check({name, " neg"}, 32'(n), 32'(en));
    check({name, " err"}, 32'(e), 32'(ee));
    check({name, " latency"}, 32'(lat), 32'(el));
    check({name, " busy_cycles"}, 32'(bc), 32'(el));
    check({name, " busy_at_done"}, 32'(bad), 32'(0));
    check({name, " done_one_cycle"}, 32'(drop), 32'(1));
  endtask

  initial begin
    logic [W-1:0] ra, rb, ed;
    logic         en, ee;
    int           el, ndone, cnt;
    int           times[3];

    vecs[0] = '{"basic",      16'h0753, 16'h0321, 16'h0432, 1'b0, 1'b0, 9};
    vecs[1] = '{"negative",   16'h0321, 16'h0753, 16'h0432, 1'b1, 1'b0, 9};
    vecs[2] = '{"min_max",    16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 9};
    vecs[3] = '{"max_min",    16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 9};
    vecs[4] = '{"equal",      16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 9};
    vecs[5] = '{"borrow",     16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 9};
    vecs[6] = '{"invalid",    16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 1};
    vecs[7] = '{"after_err",  16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 9};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    check("reset diff", 32'(diff), 32'(0));
    check("reset neg",  32'(neg),  32'(0));
    check("reset err",  32'(err),  32'(0));
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      check_op(vecs[i].name, vecs[i].av, vecs[i].bv, vecs[i].exp_diff,
               vecs[i].exp_neg, vecs[i].exp_err, vecs[i].exp_lat);
    end

    // Randomized operands against the reference model
    for (int t = 0; t < 40; t++) begin
      ra = '0; rb = '0;
      for (int i = 0; i < DIGITS; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) rb = ra;
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
        else                           rb[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      end
      model(ra, rb, ed, en, ee, el);
      check_op($sformatf("rand%0d", t), ra, rb, ed, en, ee, el);
    end

    // Back-to-back with start held high
    @(negedge clk);
    a = 16'h0753; b = 16'h0321; start = 1'b1;
    ndone = 0;
    for (int k = 0; k < 32; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        if (ndone < 3) times[ndone] = k;
        ndone++;
        check("b2b diff", 32'(diff), 32'h0432);
      end
    end
    start = 1'b0;
    check("b2b count", 32'(ndone), 32'(3));
    if (ndone >= 3) begin
      check("b2b first", 32'(times[0]), 32'(9));
      check("b2b interval1", 32'(times[1] - times[0]), 32'(10));
      check("b2b interval2", 32'(times[2] - times[1]), 32'(10));
    end
    repeat (15) @(negedge clk);

    // Start pulse mid-operation is ignored
    @(negedge clk);
    a = 16'h0753; b = 16'h0321; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    ndone = 0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 3) begin
        a = 16'h0001; b = 16'h0009; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          cnt = k;
          check("midstart diff", 32'(diff), 32'h0432);
          check("midstart neg",  32'(neg),  32'(0));
        end
      end
    end
    check("midstart latency", 32'(cnt), 32'(9));
    check("midstart single_done", 32'(ndone), 32'(1));

    // Reset asserted at E4 of an operation
    @(negedge clk);
    a = 16'h0321; b = 16'h0753; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort busy", 32'(busy), 32'(0));
    check("abort done", 32'(done), 32'(0));
    check("abort diff", 32'(diff), 32'(0));
    check("abort neg",  32'(neg),  32'(0));
    check("abort err",  32'(err),  32'(0));
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort no_done", 32'(ndone), 32'(0));
    check_op("post_abort", 16'h0321, 16'h0753, 16'h0432, 1'b1, 1'b0, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
